riscv_v_reduct_seq: RTL and testbench
=====================================

// Module: riscv_v_reduct_seq
// PURPOSE
//  Sequencer for vector reductions (vred*). Accepts one vs2 data word, the vs1[0] scalar and a one-hot osize.
//  Drives an external element-wise ALU through repeated halving folds (low half op high half) until one element remains.
//  A final pass combines that element with the scalar. Returns the scalar result to writeback.
//  Sits between issue and the vector ALU; it produces the folded operands the ALU consumes on reduction passes.
// PARAMETERS
//  DATA_WIDTH   RISCV_V_DATA_WIDTH (128)          vector datapath width in bits
//  NUM_OSIZES   RISCV_V_NUM_VALID_OSIZES (4)      element sizes 8/16/32/64, osize_vector bit i = 8<<i bits
// PORTS
//  clk              in   1            clock
//  rst_n            in   1            async active-low reset
//  req_valid        in   1            reduction request
//  req_ready        out  1            high only in IDLE
//  req_vs2          in   DATA_WIDTH   vector operand
//  req_scalar       in   64           vs1[0]; only low SEW bits used
//  req_osize_vector in   NUM_OSIZES   one-hot SEW
//  alu_req_valid    out  1            ALU pass request
//  alu_req_ready    in   1            ALU accepts pass
//  alu_src1         out  DATA_WIDTH   low half / accumulated element
//  alu_src2         out  DATA_WIDTH   high half shifted down / scalar
//  alu_osize_vector out  NUM_OSIZES   registered SEW
//  alu_rsp_valid    in   1            ALU result valid (single cycle)
//  alu_rsp_data     in   DATA_WIDTH   ALU result
//  res_valid        out  1            result available
//  res_ready        in   1            writeback accepts
//  res_data         out  64           result, zero-extended above SEW
//  res_err          out  1            osize_vector not one-hot; res_data = 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready = 1; internal registers cleared.
//  States:
//   - IDLE -(req_valid)-> ISSUE, or DONE with res_err = 1 if osize is zero or multi-hot. No ALU pass on the error path.
//   - ISSUE -(alu_req_ready)-> WAIT
//   - WAIT -(alu_rsp_valid)-> ISSUE if passes remain, else DONE
//   - DONE -(res_ready)-> IDLE
//  Request latch: on acceptance, cur = vs2, width W = DATA_WIDTH, pass_cnt = log2(DATA_WIDTH/SEW).
//  Fold pass (pass_cnt > 0):
//   - src1 = cur[W/2-1:0]; src2 = cur[W-1:W/2] >> 0 placed at bit 0. Bits >= W/2 of both are zero.
//   - On response: cur = rsp[W/2-1:0] (zero above), W = W/2, pass_cnt--.
//  Final pass (pass_cnt == 0): src1 = cur[SEW-1:0]; src2 = scalar[SEW-1:0]. Response low SEW bits -> res_data.
//  ALU pass count = log2(DATA_WIDTH/SEW) + 1, i.e. SEW8 = 5, SEW16 = 4, SEW32 = 3, SEW64 = 2.
//  ALU handshake:
//   - alu_req_valid is asserted only in ISSUE. src/osize are stable until alu_req_ready.
//   - Exactly one pass is outstanding. alu_rsp_valid outside WAIT is ignored.
//   - A response in the same cycle as the request handshake is not legal; the ALU has >= 1 cycle latency.
//  Result: res_valid/res_data/res_err are held in DONE until res_ready. req_ready stays low in DONE.
//   A new request is accepted no earlier than the cycle after the result handshake.
//  Reset mid-operation returns to IDLE immediately. A late ALU response is dropped (IDLE ignores alu_rsp_valid).
// CONFIGURATION
//  RISCV_V_REDUCT_PERF_EN defined:
//   - Adds output perf_busy_cycles [31:0], counting cycles with state != IDLE. Saturates at all ones.
//   - Adds output perf_reductions [31:0], counting completed result handshakes. Wraps.
//   - Both clear on reset.
//  Undefined: the ports and counters do not exist. Functional behaviour is identical.
// STRUCTURE
//  riscv_v_pkg additions:
//   - riscv_v_reduct_state_e {IDLE, ISSUE, WAIT, DONE}
//   - function osize_is_onehot
//   - function osize_to_sew_bits
//   - function osize_to_fold_passes
//  Sub-module riscv_v_reduct_fold (combinational): takes cur, W, final flag, scalar and SEW; produces alu_src1/alu_src2.
//  The top holds the FSM, counters and registers.
// TESTING (DATA_WIDTH = 128; bench ALU model = element-wise add, 2-cycle latency)
//  - SEW32: vs2 = {4,3,2,1}, scalar = 10.
//    Fold 1: src1 = {2,1}, src2 = {4,3}. Fold 2: src1 = 4, src2 = 6. Final: src1 = 10, src2 = 10.
//    Expect res_data = 20 after 3 passes.
//  - SEW8: all 16 bytes = 0xFF, scalar = 0x01. Expect 5 passes and res_data = 0x00000000_000000F1 (mod-256 wrap, zero-extended).
//  - osize_vector = 4'b0110. Expect the next cycle res_valid = 1, res_err = 1, res_data = 0, and alu_req_valid never asserted.
//  - Backpressure: hold alu_req_ready = 0 for 5 cycles and res_ready = 0 for 3 cycles.
//    Expect operands stable and res_valid held; req_ready = 0 throughout; result unchanged.
//  - Deassert rst_n while in WAIT, then pulse alu_rsp_valid after release.
//    Expect IDLE, req_ready = 1, no res_valid, next request correct.
//  - PERF_EN: two back-to-back SEW64 reductions, ALU latency 2 -> perf_reductions = 2; perf_busy_cycles = sum of the non-IDLE cycles.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types and helpers for the reduction sequencer.
// osize_vector bit i selects an element size of (8 << i) bits.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH       = 128;
  localparam int RISCV_V_NUM_VALID_OSIZES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } riscv_v_reduct_state_e;

  function automatic logic osize_is_onehot(input logic [3:0] osize);
    return (osize != 4'd0) && ((osize & (osize - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [6:0] osize_to_sew_bits(input logic [3:0] osize);
    logic [6:0] sew;
    sew = '0;
    for (int i = 0; i < 4; i++) begin
      if (osize[i]) sew = 7'(8 << i);
    end
    return sew;
  endfunction

  // Halving folds needed to bring dw_log2-bit data down to one element.
  function automatic int osize_to_fold_passes(input logic [3:0] osize, input int dw_log2);
    int passes;
    passes = 0;
    for (int i = 0; i < 4; i++) begin
      if (osize[i]) passes = dw_log2 - 3 - i;
    end
    return passes;
  endfunction

endpackage

// File: rtl/riscv_v_reduct_fold.sv
// Reduction operand former: low half vs high half on fold passes, element vs scalar on the final pass.
// Purely combinational, zero latency; no flow control of its own.
module riscv_v_reduct_fold #(
  parameter int DATA_WIDTH = 128,
  parameter int WW         = 8
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [WW-1:0]         width,
  input  logic                  final_pass,
  input  logic [63:0]           scalar,
  input  logic [6:0]            sew,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2
);

  logic [DATA_WIDTH-1:0] half_mask;
  logic [DATA_WIDTH-1:0] sew_mask;
  logic [WW-1:0]         half;

  always_comb begin
    half      = width >> 1;
    half_mask = ~({DATA_WIDTH{1'b1}} << half);
    sew_mask  = ~({DATA_WIDTH{1'b1}} << sew);
    if (final_pass) begin
      alu_src1 = cur & sew_mask;
      alu_src2 = DATA_WIDTH'(scalar) & sew_mask;
    end else begin
      alu_src1 = cur & half_mask;
      alu_src2 = (cur >> half) & half_mask;
    end
  end

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Vector reduction sequencer: halving folds through an external ALU, then a scalar combine pass.
// One ALU pass outstanding at a time; result held until res_ready. Optional RISCV_V_REDUCT_PERF_EN adds perf counters.
module riscv_v_reduct_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_vs2,
  input  logic [63:0]           req_scalar,
  input  logic [NUM_OSIZES-1:0] req_osize_vector,
  output logic                  alu_req_valid,
  input  logic                  alu_req_ready,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  output logic [NUM_OSIZES-1:0] alu_osize_vector,
  input  logic                  alu_rsp_valid,
  input  logic [DATA_WIDTH-1:0] alu_rsp_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [63:0]           res_data,
  output logic                  res_err
`ifdef RISCV_V_REDUCT_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_reductions
`endif
);

  localparam int PW = $clog2(DATA_WIDTH);
  localparam int WW = PW + 1;

  riscv_v_reduct_state_e state;
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] rsp_half;
  logic [WW-1:0]         width;
  logic [PW-1:0]         pass_cnt;
  logic [63:0]           scalar;
  logic [63:0]           res_mask;
  logic [6:0]            sew;

  assign sew      = osize_to_sew_bits(alu_osize_vector);
  assign rsp_half = alu_rsp_data & ~({DATA_WIDTH{1'b1}} << (width >> 1));
  assign res_mask = ~({64{1'b1}} << sew);

  riscv_v_reduct_fold #(
    .DATA_WIDTH(DATA_WIDTH),
    .WW        (WW)
  ) u_fold (
    .cur       (cur),
    .width     (width),
    .final_pass(pass_cnt == '0),
    .scalar    (scalar),
    .sew       (sew),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      alu_req_valid    <= 1'b0;
      alu_osize_vector <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_err          <= 1'b0;
      cur              <= '0;
      width            <= '0;
      pass_cnt         <= '0;
      scalar           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (osize_is_onehot(req_osize_vector)) begin
              state            <= ISSUE;
              alu_req_valid    <= 1'b1;
              cur              <= req_vs2;
              width            <= WW'(DATA_WIDTH);
              pass_cnt         <= PW'(osize_to_fold_passes(req_osize_vector, PW));
              scalar           <= req_scalar;
              alu_osize_vector <= req_osize_vector;
            end else begin
              // Malformed size: report straight away without touching the ALU.
              state     <= DONE;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
            end
          end
        end
        ISSUE: begin
          if (alu_req_ready) begin
            alu_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (alu_rsp_valid) begin
            if (pass_cnt != '0) begin
              cur           <= rsp_half;
              width         <= width >> 1;
              pass_cnt      <= pass_cnt - PW'(1);
              alu_req_valid <= 1'b1;
              state         <= ISSUE;
            end else begin
              res_valid <= 1'b1;
              res_err   <= 1'b0;
              res_data  <= alu_rsp_data[63:0] & res_mask;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef RISCV_V_REDUCT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_reductions  <= '0;
    end else begin
      if (state != IDLE && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == DONE && res_ready) perf_reductions <= perf_reductions + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Bench for riscv_v_reduct_seq: element-wise-add ALU with 2-cycle latency, reference reduction by plain summation.
module tb_riscv_v_reduct_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_vs2 = '0;
  logic [63:0]  req_scalar = '0;
  logic [3:0]   req_osize_vector = '0;
  logic         alu_req_valid;
  logic         alu_req_ready = 1'b0;
  logic [127:0] alu_src1;
  logic [127:0] alu_src2;
  logic [3:0]   alu_osize_vector;
  logic         alu_rsp_valid = 1'b0;
  logic [127:0] alu_rsp_data = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [63:0]  res_data;
  logic         res_err;
`ifdef RISCV_V_REDUCT_PERF_EN
  logic [31:0]  perf_busy_cycles;
  logic [31:0]  perf_reductions;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_v_reduct_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_vs2         (req_vs2),
    .req_scalar      (req_scalar),
    .req_osize_vector(req_osize_vector),
    .alu_req_valid   (alu_req_valid),
    .alu_req_ready   (alu_req_ready),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .alu_osize_vector(alu_osize_vector),
    .alu_rsp_valid   (alu_rsp_valid),
    .alu_rsp_data    (alu_rsp_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_err         (res_err)
`ifdef RISCV_V_REDUCT_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_reductions (perf_reductions)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] alu_add(input logic [127:0] a, input logic [127:0] b, input int sew);
    logic [127:0] r;
    logic [63:0]  m;
    logic [63:0]  ea;
    logic [63:0]  eb;
    m = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    r = '0;
    for (int i = 0; i < 128 / sew; i++) begin
      ea = 64'(a >> (i * sew)) & m;
      eb = 64'(b >> (i * sew)) & m;
      r  = r | (128'((ea + eb) & m) << (i * sew));
    end
    return r;
  endfunction

  // Full reduction with an optional stall of the first ALU pass and of the result handshake.
  task automatic run_red(input string tag, input logic [127:0] vs2, input logic [63:0] sc,
                         input logic [3:0] os, input int alu_hold, input int res_hold);
    logic [63:0]  el[16];
    logic [63:0]  m;
    logic [63:0]  tot;
    logic [127:0] e1;
    logic [127:0] e2;
    logic [127:0] s1;
    logic [127:0] s2;
    int sew, n, npass, w;
    sew = 8;
    for (int i = 0; i < 4; i++) if (os[i]) sew = 8 << i;
    m   = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    n   = 128 / sew;
    tot = sc & m;
    for (int i = 0; i < n; i++) begin
      el[i] = 64'(vs2 >> (i * sew)) & m;
      tot   = (tot + el[i]) & m;
    end
    npass = 1;
    for (int k = n; k > 1; k = k / 2) npass++;

    check($sformatf("%s:req_ready_idle", tag), 128'(req_ready), 128'd1);
    req_valid = 1'b1; req_vs2 = vs2; req_scalar = sc; req_osize_vector = os;
    tick();
    req_valid = 1'b0;

    for (int p = 0; p < npass; p++) begin
      w = 0;
      while (!alu_req_valid && w < 20) begin tick(); w++; end
      check($sformatf("%s:p%0d_issue", tag, p), 128'(alu_req_valid), 128'd1);
      if (!alu_req_valid) return;
      e1 = '0; e2 = '0;
      if (n > 1) begin
        for (int i = 0; i < n / 2; i++) begin
          e1 = e1 | (128'(el[i]) << (i * sew));
          e2 = e2 | (128'(el[i + n / 2]) << (i * sew));
        end
      end else begin
        e1 = 128'(el[0]);
        e2 = 128'(sc & m);
      end
      check($sformatf("%s:p%0d_src1", tag, p), alu_src1, e1);
      check($sformatf("%s:p%0d_src2", tag, p), alu_src2, e2);
      check($sformatf("%s:p%0d_osize", tag, p), 128'(alu_osize_vector), 128'(os));
      if (p == 0) begin
        repeat (alu_hold) begin
          tick();
          check($sformatf("%s:hold_vld", tag), 128'(alu_req_valid), 128'd1);
          check($sformatf("%s:hold_src1", tag), alu_src1, e1);
          check($sformatf("%s:hold_src2", tag), alu_src2, e2);
          check($sformatf("%s:hold_req_ready", tag), 128'(req_ready), 128'd0);
        end
      end
      s1 = alu_src1; s2 = alu_src2;
      alu_req_ready = 1'b1;
      tick();
      alu_req_ready = 1'b0;
      check($sformatf("%s:p%0d_wait", tag, p), 128'(alu_req_valid), 128'd0);
      tick();
      alu_rsp_valid = 1'b1;
      alu_rsp_data  = alu_add(s1, s2, sew);
      tick();
      alu_rsp_valid = 1'b0;
      alu_rsp_data  = '0;
      if (n > 1) begin
        for (int i = 0; i < n / 2; i++) el[i] = (el[i] + el[i + n / 2]) & m;
        n = n / 2;
      end
    end

    check($sformatf("%s:res_valid", tag), 128'(res_valid), 128'd1);
    check($sformatf("%s:res_err", tag), 128'(res_err), 128'd0);
    check($sformatf("%s:res_data", tag), 128'(res_data), 128'(tot));
    check($sformatf("%s:no_extra_pass", tag), 128'(alu_req_valid), 128'd0);
    repeat (res_hold) begin
      tick();
      check($sformatf("%s:res_held", tag), 128'(res_valid), 128'd1);
      check($sformatf("%s:res_data_held", tag), 128'(res_data), 128'(tot));
      check($sformatf("%s:req_ready_done", tag), 128'(req_ready), 128'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check($sformatf("%s:res_cleared", tag), 128'(res_valid), 128'd0);
    check($sformatf("%s:req_ready_back", tag), 128'(req_ready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bad_os[2];
    bad_os[0] = 4'b0110;
    bad_os[1] = 4'b0000;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst:req_ready", 128'(req_ready), 128'd1);
    check("rst:alu_req_valid", 128'(alu_req_valid), 128'd0);
    check("rst:res_valid", 128'(res_valid), 128'd0);
    check("rst:res_err", 128'(res_err), 128'd0);
    check("rst:res_data", 128'(res_data), 128'd0);
    check("rst:src1", alu_src1, 128'd0);
    check("rst:src2", alu_src2, 128'd0);
    check("rst:osize", 128'(alu_osize_vector), 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_red("sew32", {32'd4, 32'd3, 32'd2, 32'd1}, 64'd10, 4'b0100, 0, 0);
    run_red("sew8_ff", {128{1'b1}}, 64'h1, 4'b0001, 0, 0);
    run_red("backpressure", {32'd40, 32'd30, 32'd20, 32'd10}, 64'hFFFF_FFFF_0000_0005, 4'b0100, 5, 3);

    // Malformed osize: immediate error, no ALU activity
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_osize_vector = bad_os[k]; req_vs2 = {4{$urandom}};
      tick();
      req_valid = 1'b0;
      check("err:res_valid", 128'(res_valid), 128'd1);
      check("err:res_err", 128'(res_err), 128'd1);
      check("err:res_data", 128'(res_data), 128'd0);
      check("err:req_ready", 128'(req_ready), 128'd0);
      repeat (2) begin
        check("err:no_alu", 128'(alu_req_valid), 128'd0);
        tick();
      end
      check("err:res_held", 128'(res_err), 128'd1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("err:req_ready_back", 128'(req_ready), 128'd1);
      check("err:res_cleared", 128'(res_valid), 128'd0);
    end

    // Reset while waiting on the ALU, then a stale response
    req_valid = 1'b1; req_osize_vector = 4'b0010; req_vs2 = {$urandom, $urandom, $urandom, $urandom};
    tick();
    req_valid = 1'b0;
    alu_req_ready = 1'b1;
    tick();
    alu_req_ready = 1'b0;
    check("mrst:in_wait", 128'(alu_req_valid), 128'd0);
    rst_n = 1'b0;
    #1;
    check("mrst:req_ready", 128'(req_ready), 128'd1);
    check("mrst:alu_req_valid", 128'(alu_req_valid), 128'd0);
    tick();
    rst_n = 1'b1;
    alu_rsp_valid = 1'b1; alu_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    alu_rsp_valid = 1'b0; alu_rsp_data = '0;
    tick();
    check("mrst:late_rsp_res", 128'(res_valid), 128'd0);
    check("mrst:late_rsp_alu", 128'(alu_req_valid), 128'd0);
    check("mrst:late_rsp_ready", 128'(req_ready), 128'd1);
    run_red("after_rst", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 4'b0010, 0, 0);

    // Randomized reductions
    for (int r = 0; r < 8; r++) begin
      run_red($sformatf("rand%0d", r), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
              4'b0001 << $urandom_range(0, 3), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

`ifdef RISCV_V_REDUCT_PERF_EN
    rst_n = 1'b0;
    #1;
    check("perf:busy_rst", 128'(perf_busy_cycles), 128'd0);
    check("perf:red_rst", 128'(perf_reductions), 128'd0);
    tick();
    rst_n = 1'b1;
    run_red("perf_a", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 0, 0);
    run_red("perf_b", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 0, 0);
    // Per SEW64 reduction: 2 passes x (1 ISSUE + 2 WAIT) + 1 DONE cycle.
    check("perf:reductions", 128'(perf_reductions), 128'd2);
    check("perf:busy_cycles", 128'(perf_busy_cycles), 128'(2 * (2 * (1 + 2) + 1)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
